sata_oob_ctrl: RTL and testbench
================================

# sata_oob_ctrl

Host-side Serial ATA out-of-band link initialisation controller. It sequences the OOB coder through COMRESET and COMWAKE, watches the OOB detector for the device's COMINIT and COMWAKE, then runs the D10.2/ALIGN/SYNC handshake on the 32-bit PHY datapath. It asserts `linkup` once the device is synchronised. It sits between the PHY wrapper (coder, detector, transceiver data ports) and the link layer. It retries with timeouts indefinitely.

## Interface
- `CLKFREQ`, 100_000: clk frequency, kHz.
- `RETRYUS`, 10_000: timeout waiting for device COMINIT or COMWAKE, µs.
- `ALIGNUS`, 880: timeout waiting for device ALIGN, µs.
- Timeout cycle counts are `(RETRYUS*CLKFREQ)/1000` and `(ALIGNUS*CLKFREQ)/1000`. Timer width is `$clog2` of the larger count plus 1.

Ports:
- `clk`  in  1  clock
- `reset`  in  1  asynchronous, active-high reset
- `coder_ready`  in  1  OOB coder idle and accepting a command
- `cominit`  out  1  one-cycle command to the coder: send COMRESET/COMINIT burst train
- `comwake`  out  1  one-cycle command to the coder: send COMWAKE burst train
- `oobfinish`  out  1  OOB phase over; coder releases electrical idle
- `rx_cominit`  in  1  detector: COMINIT received (one-cycle pulse)
- `rx_comwake`  in  1  detector: COMWAKE received (one-cycle pulse)
- `rxdata`  in  32  received dword, byte 0 in [7:0]
- `rxdatak`  in  4  K-character flags per byte
- `txdata`  out  32  transmitted dword
- `txdatak`  out  4  K flags for txdata
- `linkup`  out  1  link established
- `retries`  out  8  saturating count of timeout-driven restarts

## Operation
- Constants:
  - D10.2 = 32'h4A4A4A4A, k=4'b0000.
  - ALIGN = 32'h7B4A4ABC, k=4'b0001.
  - A "non-ALIGN primitive" is any dword with rxdatak==4'b0001 and rxdata!=ALIGN.
- States and transitions:
  - `st_reset`: wait for coder_ready=1. In that cycle, pulse cominit and go to `st_wait_cominit`.
  - `st_wait_cominit`:
    - rx_cominit=1 → `st_wake`.
    - Timer reaches RETRY count → `st_reset`, retries+1.
  - `st_wake`: wait for coder_ready=1. In that cycle, pulse comwake and go to `st_wait_comwake`.
  - `st_wait_comwake`:
    - rx_comwake=1 → `st_wait_coder`.
    - Timeout → `st_reset`, retries+1.
  - `st_wait_coder`: wait for coder_ready=1 (the COMWAKE train is finished), then go to `st_send_d10`.
  - `st_send_d10`:
    - oobfinish=1; txdata/txdatak = D10.2.
    - An ALIGN is received (exact dword match) → `st_send_align`.
    - ALIGN timeout → `st_reset`, retries+1.
  - `st_send_align`:
    - oobfinish=1; tx = ALIGN.
    - Three consecutive non-ALIGN primitives → `st_linkup`.
    - Any other dword clears the consecutive count.
    - ALIGN timeout → `st_reset`, retries+1.
  - `st_linkup`:
    - linkup=1, oobfinish=1; tx = ALIGN (the link layer muxes its own data downstream).
    - rx_cominit=1 → `st_reset`. This is a device-initiated reset and does not count as a retry.
- Outputs by state:
  - In all states other than `st_send_d10`, `st_send_align` and `st_linkup`: oobfinish=0, tx=D10.2.
  - cominit and comwake are never high together.
  - Neither is ever driven while coder_ready=0.
- Timer:
  - Cleared on every state change; increments every cycle otherwise.
  - Compared against the count for the current state.
  - It never wraps, because the state always exits at the compare.
- retries saturates at 8'hFF.
- Simultaneous events:
  - Qualifying input and timeout in the same cycle → the input wins and there is no retry.
  - rx_cominit in any state other than `st_wait_cominit` or `st_linkup` is ignored.

## Timing
- Reset values:
  - state `st_reset`; cominit=0, comwake=0, oobfinish=0.
  - txdata=32'h4A4A4A4A, txdatak=0, linkup=0, retries=0.
  - Timer and consecutive counter = 0.
- All outputs are registered.
- cominit and comwake are high for exactly one cycle.
  - They appear one cycle after coder_ready is sampled high in `st_reset` or `st_wake`.
  - The following cycle, the controller is already in the wait state.
- Reaction latency to rx_cominit, rx_comwake or rxdata: one cycle from sampling to state/output change.
  - linkup rises one cycle after the third non-ALIGN primitive is sampled.
  - oobfinish falls one cycle after a timeout or rx_cominit in linkup.
- Asserting reset mid-operation immediately forces all reset values. After release, the sequence restarts from `st_reset`.

## Test plan
- **Normal bring-up.** CLKFREQ=100_000, RETRYUS=10, ALIGNUS=5. The model returns rx_cominit 50 cycles after cominit, rx_comwake 50 cycles after comwake, then ALIGN ×4 followed by SYNC ×3 → cominit and comwake each pulse once; tx goes D10.2 → ALIGN; linkup=1; retries=0.
- **Missing COMINIT.** No device response → cominit re-pulses every 1000 cycles (+1 for the coder handshake); retries counts 1, 2, 3; linkup stays 0.
- **Missing ALIGN.** The device responds through COMWAKE but never sends ALIGN → after 500 cycles in `st_send_d10`, oobfinish=0, retries=1, and a new cominit is issued.
- **Broken SYNC run.** Sequence SYNC, SYNC, D-data (k=0), SYNC, SYNC, SYNC → linkup rises only after the final SYNC.
- **Device reset while linked.** rx_cominit in `st_linkup` → next cycle linkup=0 and oobfinish=0; retries unchanged; a COMRESET is reissued.
- **Reset mid-operation.** Assert reset in `st_send_align` → all outputs return to reset values asynchronously; after release, the full bring-up succeeds.

Source files
------------

// File: rtl/sata_oob_ctrl.sv
// sata_oob_ctrl: host-side SATA OOB link bring-up (COMRESET/COMWAKE, then D10.2/ALIGN/SYNC handshake)
module sata_oob_ctrl #(
    parameter int CLKFREQ = 100_000,
    parameter int RETRYUS = 10_000,
    parameter int ALIGNUS = 880
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        coder_ready,
    output logic        cominit,
    output logic        comwake,
    output logic        oobfinish,
    input  logic        rx_cominit,
    input  logic        rx_comwake,
    input  logic [31:0] rxdata,
    input  logic [3:0]  rxdatak,
    output logic [31:0] txdata,
    output logic [3:0]  txdatak,
    output logic        linkup,
    output logic [7:0]  retries
);
    localparam int retry_cyc = (RETRYUS * CLKFREQ) / 1000;
    localparam int align_cyc = (ALIGNUS * CLKFREQ) / 1000;
    localparam int max_cyc   = (retry_cyc > align_cyc) ? retry_cyc : align_cyc;
    localparam int tw        = $clog2(max_cyc) + 1;
    localparam logic [tw-1:0] retry_lim = tw'(retry_cyc - 1);
    localparam logic [tw-1:0] align_lim = tw'(align_cyc - 1);

    localparam logic [31:0] d10_2 = 32'h4A4A4A4A;
    localparam logic [31:0] align = 32'h7B4A4ABC;

    localparam logic [2:0] st_reset        = 3'd0;
    localparam logic [2:0] st_wait_cominit = 3'd1;
    localparam logic [2:0] st_wake         = 3'd2;
    localparam logic [2:0] st_wait_comwake = 3'd3;
    localparam logic [2:0] st_wait_coder   = 3'd4;
    localparam logic [2:0] st_send_d10     = 3'd5;
    localparam logic [2:0] st_send_align   = 3'd6;
    localparam logic [2:0] st_linkup       = 3'd7;

    logic [2:0]    state, nxt;
    logic [tw-1:0] timer;
    logic [1:0]    cnt;
    logic          timed, in_align_phase, tmo, is_align, is_prim, retry;

    assign in_align_phase = (state == st_send_d10) || (state == st_send_align);
    assign timed    = in_align_phase || (state == st_wait_cominit) || (state == st_wait_comwake);
    // The timer is cleared on entry, so hitting lim-1 means lim cycles spent in the state.
    assign tmo      = timed && (timer == (in_align_phase ? align_lim : retry_lim));
    assign is_align = (rxdatak == 4'b0001) && (rxdata == align);
    assign is_prim  = (rxdatak == 4'b0001) && (rxdata != align);

    // Qualifying inputs are tested before the timeout so they win a same-cycle tie.
    always_comb begin
        nxt   = state;
        retry = 1'b0;
        case (state)
            st_reset:        nxt = coder_ready ? st_wait_cominit : st_reset;
            st_wait_cominit: begin
                nxt   = rx_cominit ? st_wake : (tmo ? st_reset : state);
                retry = !rx_cominit && tmo;
            end
            st_wake:         nxt = coder_ready ? st_wait_comwake : st_wake;
            st_wait_comwake: begin
                nxt   = rx_comwake ? st_wait_coder : (tmo ? st_reset : state);
                retry = !rx_comwake && tmo;
            end
            st_wait_coder:   nxt = coder_ready ? st_send_d10 : st_wait_coder;
            st_send_d10:     begin
                nxt   = is_align ? st_send_align : (tmo ? st_reset : state);
                retry = !is_align && tmo;
            end
            st_send_align:   begin
                nxt   = (is_prim && cnt == 2'd2) ? st_linkup : (tmo ? st_reset : state);
                retry = !(is_prim && cnt == 2'd2) && tmo;
            end
            st_linkup:       nxt = rx_cominit ? st_reset : st_linkup;
            default:         nxt = st_reset;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= st_reset;
            timer     <= '0;
            cnt       <= 2'd0;
            cominit   <= 1'b0;
            comwake   <= 1'b0;
            oobfinish <= 1'b0;
            txdata    <= d10_2;
            txdatak   <= 4'b0000;
            linkup    <= 1'b0;
            retries   <= 8'd0;
        end else begin
            state     <= nxt;
            timer     <= (nxt != state || !timed) ? '0 : timer + 1'b1;
            cnt       <= (state == st_send_align && nxt == st_send_align && is_prim) ? cnt + 2'd1 : 2'd0;
            cominit   <= (state == st_reset) && coder_ready;
            comwake   <= (state == st_wake) && coder_ready;
            oobfinish <= (nxt == st_send_d10) || (nxt == st_send_align) || (nxt == st_linkup);
            txdata    <= (nxt == st_send_align || nxt == st_linkup) ? align : d10_2;
            txdatak   <= (nxt == st_send_align || nxt == st_linkup) ? 4'b0001 : 4'b0000;
            linkup    <= nxt == st_linkup;
            if (retry && retries != 8'hFF)
                retries <= retries + 8'd1;
        end
    end
endmodule

// File: tb/tb_sata_oob_ctrl.sv
// tb_sata_oob_ctrl: directed bring-up scenarios; a monitor checks every output change against a queue of expected snapshots.
module tb_sata_oob_ctrl;
    localparam logic [31:0] D10  = 32'h4A4A4A4A;
    localparam logic [31:0] ALN  = 32'h7B4A4ABC;
    localparam logic [31:0] SYNC = 32'hB5B5957C;
    localparam logic [31:0] DDAT = 32'h12345678;

    logic        clk = 1'b0;
    logic        reset, coder_ready, rx_cominit, rx_comwake;
    logic [31:0] rxdata, txdata;
    logic [3:0]  rxdatak, txdatak;
    logic        cominit, comwake, oobfinish, linkup;
    logic [7:0]  retries;

    sata_oob_ctrl #(.CLKFREQ(100_000), .RETRYUS(10), .ALIGNUS(5)) dut (
        .clk(clk), .reset(reset), .coder_ready(coder_ready),
        .cominit(cominit), .comwake(comwake), .oobfinish(oobfinish),
        .rx_cominit(rx_cominit), .rx_comwake(rx_comwake),
        .rxdata(rxdata), .rxdatak(rxdatak),
        .txdata(txdata), .txdatak(txdatak),
        .linkup(linkup), .retries(retries)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [47:0] v;
        int          dl;
        string       nm;
    } exp_t;

    exp_t q[$];
    int   n_chk = 0, n_fail = 0, cyc = 0, last_cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Snapshot layout: {cominit, comwake, oobfinish, linkup, txdatak, txdata, retries}; dl = cycles since previous change (0 = any)
    task automatic push(input logic ci, input logic cw, input logic oob, input logic lu,
                        input logic [3:0] k, input logic [31:0] d, input logic [7:0] r,
                        input int dl, input string nm);
        exp_t e;
        e.v  = {ci, cw, oob, lu, k, d, r};
        e.dl = dl;
        e.nm = nm;
        q.push_back(e);
    endtask

    initial begin
        logic [47:0] prev, cur;
        exp_t e;
        prev = 'x;
        forever begin
            @(negedge clk or posedge reset);
            #1;
            cur = {cominit, comwake, oobfinish, linkup, txdatak, txdata, retries};
            if (cur !== prev) begin
                n_chk++;
                if (q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_change: got %h at cycle %0d, expected no change", cur, cyc);
                end else begin
                    e = q.pop_front();
                    if (cur !== e.v || (e.dl != 0 && cyc - last_cyc != e.dl)) begin
                        n_fail++;
                        $display("FAIL %s: got %h after %0d cycles, expected %h after %0d cycles",
                                 e.nm, cur, cyc - last_cyc, e.v, e.dl);
                    end
                end
                last_cyc = cyc;
                prev     = cur;
            end
        end
    end

    task automatic no_response(input logic [7:0] r, input int n, input int d0);
        for (int k = 0; k < n; k++) begin
            push(1, 0, 0, 0, 4'h0, D10, r + 8'(k), (k == 0) ? d0 : 1, "cominit_pulse");
            push(0, 0, 0, 0, 4'h0, D10, r + 8'(k), 1, "cominit_end");
            push(0, 0, 0, 0, 4'h0, D10, r + 8'(k + 1), 999, "cominit_timeout");
            repeat (1001) @(negedge clk);
        end
    endtask

    task automatic dev_reset(input logic [7:0] r, input int hold);
        push(0, 0, 0, 0, 4'h0, D10, r, 3, "device_cominit");
        repeat (2) @(negedge clk);
        rx_cominit = 1'b1;
        if (hold > 0) coder_ready = 1'b0;
        @(negedge clk);
        rx_cominit = 1'b0;
        repeat (hold) @(negedge clk);
        coder_ready = 1'b1;
    endtask

    // mode 0: normal SYNC run, 1: broken SYNC run, 2: no ALIGN, 3: reset asserted in send_align
    task automatic bringup(input logic [7:0] r, input int mode, input int d0, input int dw);
        logic [31:0] sd[$];
        logic [3:0]  sk[$];
        push(1, 0, 0, 0, 4'h0, D10, r, d0, "cominit_pulse");
        push(0, 0, 0, 0, 4'h0, D10, r, 1, "cominit_end");
        push(0, 1, 0, 0, 4'h0, D10, r, 50, "comwake_pulse");
        push(0, 0, 0, 0, 4'h0, D10, r, 1, "comwake_end");
        push(0, 0, 1, 0, 4'h0, D10, r, 3 + dw, "send_d10");
        if (mode == 2) push(0, 0, 0, 0, 4'h0, D10, r + 8'd1, 500, "align_timeout");
        else           push(0, 0, 1, 0, 4'h1, ALN, r, 1, "send_align");
        if (mode < 2)  push(0, 0, 1, 1, 4'h1, ALN, r, (mode == 1) ? 9 : 6, "linkup");
        if (mode == 3) push(0, 0, 0, 0, 4'h0, D10, 8'd0, 0, "async_reset");
        coder_ready = 1'b1;
        repeat (50) @(negedge clk);
        rx_cominit = 1'b1;
        @(negedge clk);
        rx_cominit = 1'b0;
        repeat (dw) @(negedge clk);
        rx_comwake  = 1'b1;
        coder_ready = 1'b0;
        @(negedge clk);
        rx_comwake = 1'b0;
        @(negedge clk);
        rx_cominit = 1'b1;
        @(negedge clk);
        rx_cominit = 1'b0;
        @(negedge clk);
        coder_ready = 1'b1;
        @(negedge clk);
        if (mode == 2) begin
            repeat (500) @(negedge clk);
        end else if (mode == 3) begin
            rxdata = ALN;  rxdatak = 4'h1;
            @(negedge clk);
            rxdata = SYNC; rxdatak = 4'h1;
            @(negedge clk);
            #2 reset = 1'b1;
            rxdata = D10;  rxdatak = 4'h0;
            repeat (3) @(negedge clk);
            reset = 1'b0;
        end else begin
            repeat (4) begin sd.push_back(ALN); sk.push_back(4'h1); end
            if (mode == 1) begin
                repeat (2) begin sd.push_back(SYNC); sk.push_back(4'h1); end
                sd.push_back(DDAT); sk.push_back(4'h0);
            end
            repeat (3) begin sd.push_back(SYNC); sk.push_back(4'h1); end
            for (int i = 0; i < sd.size(); i++) begin
                rxdata  = sd[i];
                rxdatak = sk[i];
                @(negedge clk);
            end
            rxdata  = D10;
            rxdatak = 4'h0;
        end
    endtask

    initial begin
        exp_t e;
        reset       = 1'b1;
        coder_ready = 1'b1;
        rx_cominit  = 1'b0;
        rx_comwake  = 1'b0;
        rxdata      = D10;
        rxdatak     = 4'h0;
        push(0, 0, 0, 0, 4'h0, D10, 8'd0, 0, "reset_state");
        repeat (3) @(negedge clk);
        reset = 1'b0;
        no_response(8'd0, 3, 0);
        bringup(8'd3, 0, 1, 50);
        dev_reset(8'd3, 0);
        bringup(8'd3, 1, 1, 50);
        dev_reset(8'd3, 4);
        bringup(8'd3, 2, 5, 50);
        bringup(8'd4, 0, 1, 1000);
        dev_reset(8'd4, 0);
        bringup(8'd4, 3, 1, 50);
        bringup(8'd0, 0, 0, 50);
        repeat (20) @(negedge clk);
        while (q.size() > 0) begin
            e = q.pop_front();
            n_chk++;
            n_fail++;
            $display("FAIL %s: got no output change, expected %h", e.nm, e.v);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
